// File: rtl/axi4l_regs.sv
// AXI4-Lite slave register bank.
// Software-visible 32-bit registers: R/W registers drive ctrl_out, registers
// flagged in RO_MASK return live status_in slices. Write and read channels are
// independent single-outstanding engines answering OKAY or SLVERR.
//
// Ports:
//   axi4l_aclk, axi4l_arstn   clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*         AXI4-Lite write address / data / response
//   s_ar*, s_r*               AXI4-Lite read address / data
//   ctrl_out                  R/W register contents, register i at [i*32 +: 32]
//   status_in                 status values returned by read-only registers
//   wr_pulse, rd_pulse        one-cycle strobe per register written / read
module axi4l_regs #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arstn,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Word address must fall inside the register window.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 2) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  // State registers
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

  logic                  w_hit;
  logic                  r_hit;
  logic                  w_in_range;
  logic                  r_in_range;

  // Write engine: independent AW/W capture, commit once both are held.
  always_comb begin
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    w_hit      = 1'b0;
    w_in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (s_awvalid && awready_q) begin
      aw_cap_d = 1'b1;
      awaddr_d = s_awaddr;
    end
    if (s_wvalid && wready_q) begin
      w_cap_d = 1'b1;
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end

    if (bvalid_q) begin
      if (s_bready) begin
        bvalid_d = 1'b0;
        aw_cap_d = 1'b0;
        w_cap_d  = 1'b0;
      end
    end else if (aw_cap_d && w_cap_d) begin
      // Commit uses the values captured on this very edge when they arrive now.
      w_in_range = addr_in_range(awaddr_d);
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_in_range && !RO_MASK[i] && (awaddr_d[2 +: IDX_W] == IDX_W'(i))) begin
          w_hit         = 1'b1;
          wr_pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb_d[b]) begin
              regs_d[i][b*8 +: 8] = wdata_d[b*8 +: 8];
            end
          end
        end
      end
      bvalid_d = 1'b1;
      bresp_d  = w_hit ? RESP_OKAY : RESP_SLVERR;
    end

    awready_d = !aw_cap_d && !bvalid_d;
    wready_d  = !w_cap_d && !bvalid_d;
  end

  // Read engine: registers pre-write register value or live status.
  always_comb begin
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_pulse_d = '0;
    r_hit      = 1'b0;
    r_in_range = 1'b0;

    if (rvalid_q) begin
      if (s_rready) begin
        rvalid_d = 1'b0;
      end
    end else if (s_arvalid && arready_q) begin
      r_in_range = addr_in_range(s_araddr);
      rdata_d    = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (r_in_range && (s_araddr[2 +: IDX_W] == IDX_W'(i))) begin
          r_hit         = 1'b1;
          rd_pulse_d[i] = 1'b1;
          rdata_d       = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
      end
      rvalid_d = 1'b1;
      rresp_d  = r_hit ? RESP_OKAY : RESP_SLVERR;
    end

    arready_d = !rvalid_d;
  end

  // State register
  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_pulse_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  // Register contents to fabric; read-only slots present zero.
  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign wr_pulse  = wr_pulse_q;
  assign rd_pulse  = rd_pulse_q;

endmodule

// File: tb/tb_axi4l_regs.sv
// Directed self-checking bench for axi4l_regs (4 registers, register 3 read-only).
module tb_axi4l_regs;

  logic         aclk;
  logic         arst;
  logic [31:0]  s_awaddr;
  logic         s_awvalid;
  logic         s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready;
  logic [31:0]  s_araddr;
  logic         s_arvalid;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready;
  logic [127:0] ctrl_out;
  logic [127:0] status_in;
  logic [3:0]   wr_pulse;
  logic [3:0]   rd_pulse;

  int checks = 0;
  int errors = 0;

  axi4l_regs #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (4),
    .RO_MASK    (4'b1000),
    .RESET_VALUE(32'h0)
  ) dut (
    .axi4l_aclk (aclk),
    .axi4l_arstn(arst),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .ctrl_out   (ctrl_out),
    .status_in  (status_in),
    .wr_pulse   (wr_pulse),
    .rd_pulse   (rd_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Full write transaction; call at posedge+1.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pacc, output int pcyc,
                           output bit tmo);
    bit aw_now, w_now, got;
    resp = 2'b11; pacc = '0; pcyc = 0; tmo = 1'b0; got = 1'b0;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      @(posedge aclk); #1;
      if (aw_now) s_awvalid = 1'b0;
      if (w_now)  s_wvalid  = 1'b0;
      if (wr_pulse != 4'b0) begin pacc |= wr_pulse; pcyc++; end
      if (s_bvalid) begin resp = s_bresp; got = 1'b1; end
    end
    if (!got) begin tmo = 1'b1; s_awvalid = 1'b0; s_wvalid = 1'b0; end
    @(posedge aclk); #1;
    if (wr_pulse != 4'b0) begin pacc |= wr_pulse; pcyc++; end
    s_bready = 1'b0;
  endtask

  // Full read transaction; call at posedge+1.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] pacc, output bit tmo);
    bit ar_now, got;
    data = 32'hxxxx_xxxx; resp = 2'b11; pacc = '0; tmo = 1'b0; got = 1'b0;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      ar_now = s_arvalid && s_arready;
      @(posedge aclk); #1;
      if (ar_now) s_arvalid = 1'b0;
      pacc |= rd_pulse;
      if (s_rvalid) begin data = s_rdata; resp = s_rresp; got = 1'b1; end
    end
    if (!got) begin tmo = 1'b1; s_arvalid = 1'b0; end
    @(posedge aclk); #1;
    pacc |= rd_pulse;
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #3;
    checks++;
    if (s_awready !== 1'b0 || s_wready !== 1'b0 || s_arready !== 1'b0 || s_bvalid !== 1'b0 ||
        s_rvalid !== 1'b0 || s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: awr=%b wr=%b arr=%b bv=%b rv=%b br=%b rr=%b rd=%h required all 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata);
    end
    checks++;
    if (ctrl_out !== 128'h0 || wr_pulse !== 4'b0 || rd_pulse !== 4'b0) begin
      errors++;
      $display("FAIL reset_regs: ctrl_out=%h wr=%b rd=%b required 0", ctrl_out, wr_pulse, rd_pulse);
    end
    @(negedge aclk);
    arst = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: awr=%b wr=%b arr=%b required 1 1 1", s_awready, s_wready, s_arready);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; bit t;
    for (int a = 0; a < 4; a++) begin
      axi_read(32'(a), d, r, p, t);
      checks++;
      if (t || r !== 2'b00 || d !== 32'h0 || p !== 4'b0001) begin
        errors++;
        $display("FAIL decode_unaligned_%0d: tmo=%0b resp=%b data=%h pulse=%b required resp 00 data 0 pulse 0001",
                 a, t, r, d, p);
      end
    end
    axi_read(32'hC, d, r, p, t);
    checks++;
    if (t || r !== 2'b00 || d !== 32'h0) begin
      errors++;
      $display("FAIL decode_reg3: tmo=%0b resp=%b data=%h required 00 00000000", t, r, d);
    end
  endtask

  task automatic test_full_write();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; int pc; bit t;
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, r, p, pc, t);
    checks++;
    if (t || r !== 2'b00 || p !== 4'b0010 || pc != 1) begin
      errors++;
      $display("FAIL write_full_resp: tmo=%0b resp=%b pulse=%b cycles=%0d required 00 0010 1", t, r, p, pc);
    end
    checks++;
    if (ctrl_out[63:32] !== 32'hDEADBEEF || ctrl_out[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL write_full_ctrl: ctrl_out=%h required reg1 deadbeef", ctrl_out);
    end
    axi_read(32'h4, d, r, p, t);
    checks++;
    if (t || r !== 2'b00 || d !== 32'hDEADBEEF || p !== 4'b0010) begin
      errors++;
      $display("FAIL write_full_read: resp=%b data=%h pulse=%b required 00 deadbeef 0010", r, d, p);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; int pc; bit t;
    axi_write(32'h4, 32'h12345678, 4'h3, r, p, pc, t);
    axi_read(32'h4, d, r, p, t);
    checks++;
    if (t || d !== 32'hDEAD5678) begin
      errors++;
      $display("FAIL strobe_partial: data=%h required dead5678", d);
    end
    axi_write(32'h4, 32'hFFFFFFFF, 4'h0, r, p, pc, t);
    checks++;
    if (t || r !== 2'b00 || p !== 4'b0010 || pc != 1) begin
      errors++;
      $display("FAIL strobe_zero_resp: resp=%b pulse=%b cycles=%0d required 00 0010 1", r, p, pc);
    end
    checks++;
    if (ctrl_out[63:32] !== 32'hDEAD5678) begin
      errors++;
      $display("FAIL strobe_zero_data: reg1=%h required dead5678", ctrl_out[63:32]);
    end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; int pc; bit t; bit bad;
    s_awaddr = 32'h8; s_awvalid = 1'b1; s_bready = 1'b0;
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (s_awready !== 1'b0 || s_wready !== 1'b1 || s_bvalid !== 1'b0) bad = 1'b1;
      if (c < 2) begin @(posedge aclk); #1; end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL awfirst_capture: awready=%b wready=%b bvalid=%b required 0 1 0", s_awready, s_wready, s_bvalid);
    end
    s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_wvalid = 1'b0;
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse !== 4'b0100 || ctrl_out[95:64] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL awfirst_commit: bvalid=%b bresp=%b pulse=%b reg2=%h required 1 00 0100 0badf00d",
               s_bvalid, s_bresp, wr_pulse, ctrl_out[95:64]);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0 || wr_pulse !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL awfirst_hold: bvalid=%b bresp=%b awready=%b pulse=%b required 1 00 0 0000",
               s_bvalid, s_bresp, s_awready, wr_pulse);
    end
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
      errors++;
      $display("FAIL awfirst_bhandshake: bvalid=%b awready=%b wready=%b required 0 1 1", s_bvalid, s_awready, s_wready);
    end
    axi_write(32'h8, 32'hCAFEBABE, 4'hC, r, p, pc, t);
    axi_read(32'h8, d, r, p, t);
    checks++;
    if (t || r !== 2'b00 || d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL awfirst_next: resp=%b data=%h required 00 cafef00d", r, d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; int pc; bit t;
    axi_write(32'h10, 32'h11111111, 4'hF, r, p, pc, t);
    checks++;
    if (t || r !== 2'b10 || p !== 4'b0 || ctrl_out !== {32'h0, 32'hCAFEF00D, 32'hDEAD5678, 32'h0}) begin
      errors++;
      $display("FAIL oor_write: tmo=%0b resp=%b pulse=%b ctrl_out=%h required 10 0000 unchanged", t, r, p, ctrl_out);
    end
    axi_read(32'h10, d, r, p, t);
    checks++;
    if (t || r !== 2'b10 || d !== 32'h0 || p !== 4'b0) begin
      errors++;
      $display("FAIL oor_read: resp=%b data=%h pulse=%b required 10 00000000 0000", r, d, p);
    end
    status_in[127:96] = 32'hA5A5A5A5;
    axi_write(32'hC, 32'h22222222, 4'hF, r, p, pc, t);
    checks++;
    if (t || r !== 2'b10 || p !== 4'b0 || ctrl_out[127:96] !== 32'h0) begin
      errors++;
      $display("FAIL ro_write: resp=%b pulse=%b reg3=%h required 10 0000 00000000", r, p, ctrl_out[127:96]);
    end
    axi_read(32'hC, d, r, p, t);
    checks++;
    if (t || r !== 2'b00 || d !== 32'hA5A5A5A5 || p !== 4'b1000) begin
      errors++;
      $display("FAIL ro_read: resp=%b data=%h pulse=%b required 00 a5a5a5a5 1000", r, d, p);
    end
  endtask

  task automatic test_simultaneous();
    s_awaddr = 32'h4; s_wdata = 32'h11112222; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h4; s_arvalid = 1'b1;
    s_bready = 1'b0; s_rready = 1'b0;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'hDEAD5678 || s_bvalid !== 1'b1 || ctrl_out[63:32] !== 32'h11112222) begin
      errors++;
      $display("FAIL simul_same_reg: rvalid=%b rdata=%h bvalid=%b reg1=%h required 1 dead5678 1 11112222",
               s_rvalid, s_rdata, s_bvalid, ctrl_out[63:32]);
    end
    s_bready = 1'b1; s_rready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; int pc; bit t; bit bad;
    s_awaddr = 32'h0; s_wdata = 32'h77777777; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h8; s_arvalid = 1'b1;
    s_bready = 1'b0; s_rready = 1'b0;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    checks++;
    if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1 || ctrl_out[31:0] !== 32'h77777777) begin
      errors++;
      $display("FAIL midflight_setup: bvalid=%b rvalid=%b reg0=%h required 1 1 77777777",
               s_bvalid, s_rvalid, ctrl_out[31:0]);
    end
    #2 arst = 1'b1;
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || ctrl_out !== 128'h0 || s_awready !== 1'b0) begin
      errors++;
      $display("FAIL midflight_async: bvalid=%b rvalid=%b awready=%b ctrl_out=%h required 0 0 0 0",
               s_bvalid, s_rvalid, s_awready, ctrl_out);
    end
    #2 arst = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || s_awready !== 1'b1 || s_arready !== 1'b1) bad = 1'b1;
    end
    s_bready = 1'b0; s_rready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midflight_no_response: bvalid=%b rvalid=%b awready=%b arready=%b required 0 0 1 1",
               s_bvalid, s_rvalid, s_awready, s_arready);
    end
    axi_write(32'h0, 32'h5A5A5A5A, 4'hF, r, p, pc, t);
    checks++;
    if (t || r !== 2'b00 || p !== 4'b0001) begin
      errors++;
      $display("FAIL midflight_fresh_write: tmo=%0b resp=%b pulse=%b required 00 0001", t, r, p);
    end
    axi_read(32'h0, d, r, p, t);
    checks++;
    if (t || r !== 2'b00 || d !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL midflight_fresh_read: tmo=%0b resp=%b data=%h required 00 5a5a5a5a", t, r, d);
    end
  endtask

  initial begin
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; status_in = '0;
    test_reset();
    test_decode();
    test_full_write();
    test_strobe();
    test_aw_before_w();
    test_errors();
    test_simultaneous();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
